fir_filter: RTL

FIR_FILTER -- requirements
Module: fir_filter

---
 rtl/fir_filter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fir_filter.sv
// Four-stage pipelined FIR filter with host-started run mode and a coefficient RAM
// that is writable only while idle.
package fir_pkg;
  parameter logic [31:0] HC_CONTROL_START = 32'hA5A5_0001;
endpackage

module fir_filter
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = 16,
  parameter int unsigned COEF_SHIFT = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 hc_control,
  input  logic                        coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
  input  logic [7:0]                  coef_wr_data,
  input  logic [7:0]                  data_in,
  input  logic                        valid_in,
  output logic [7:0]                  data_out,
  output logic                        valid_out,
  output logic                        busy,
  output logic [31:0]                 sample_count
);

  localparam int unsigned AW    = $clog2(NUM_TAPS);
  localparam int unsigned ACC_W = 17 + AW;
  localparam int          COEF0_INT = (COEF_SHIFT >= 7) ? 127 : (1 << COEF_SHIFT);
  localparam logic signed [7:0]       COEF0   = 8'(COEF0_INT);
  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1 << (COEF_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(255);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                  state_q;
  logic                    start;
  logic                    accept;
  logic [7:0]              x_q    [NUM_TAPS];
  logic signed [7:0]       coef_q [NUM_TAPS];
  logic signed [16:0]      p_q    [NUM_TAPS];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shr;
  logic [7:0]              sat;
  logic                    v1_q, v2_q, v3_q;

  assign start  = (state_q == S_IDLE) && (hc_control == HC_CONTROL_START);
  assign accept = (state_q == S_RUN) && valid_in;
  assign busy   = (state_q == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (start) begin
      state_q <= S_RUN;
    end
  end

  // Writes land in the START cycle too, since state_q is still S_IDLE then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_q[k] <= (k == 0) ? COEF0 : 8'sd0;
      end
    end else if ((state_q == S_IDLE) && coef_wr_en) begin
      coef_q[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Stage 1: delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= 8'h00;
      end
      v1_q <= 1'b0;
    end else begin
      v1_q <= accept;
      if (start) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          x_q[k] <= 8'h00;
        end
      end else if (accept) begin
        x_q[0] <= data_in;
        for (int k = 1; k < NUM_TAPS; k++) begin
          x_q[k] <= x_q[k-1];
        end
      end
    end
  end

  // Stage 2: per-tap products; the sample is zero-extended so it stays non-negative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_q[k] <= 17'sd0;
      end
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q && !start;
      if (v1_q) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          p_q[k] <= 17'(signed'({1'b0, x_q[k]})) * 17'(coef_q[k]);
        end
      end
    end
  end

  always_comb begin
    acc_sum = ROUND;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_sum = acc_sum + ACC_W'(p_q[k]);
    end
  end

  // Stage 3: rounded accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      v3_q  <= 1'b0;
    end else begin
      v3_q <= v2_q && !start;
      if (v2_q) begin
        acc_q <= acc_sum;
      end
    end
  end

  always_comb begin
    acc_shr = acc_q >>> COEF_SHIFT;
    if (acc_shr < 0) begin
      sat = 8'h00;
    end else if (acc_shr > OUT_MAX) begin
      sat = 8'hFF;
    end else begin
      sat = acc_shr[7:0];
    end
  end

  // Stage 4: saturated output; data_out holds between valid samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out     <= 8'h00;
      valid_out    <= 1'b0;
      sample_count <= 32'd0;
    end else begin
      valid_out <= v3_q && !start;
      if (v3_q) begin
        data_out <= sat;
      end
      if (start) begin
        sample_count <= 32'd0;
      end else if (v3_q) begin
        sample_count <= sample_count + 32'd1;
      end
    end
  end

endmodule
